// File: rtl/d_reg_bank.sv
// Multi-channel D register bank: per-channel load/shift/clear under a shared
// enable and mode bus, with change-detect pulses and a snapshot register
// handed to a consumer through a valid/ack handshake.
module d_reg_bank #(
    parameter int unsigned         WIDTH      = 8,
    parameter int unsigned         CHANNELS   = 4,
    parameter logic [WIDTH-1:0]    RESET_VAL  = '0,
    parameter bit                  SHIFT_LEFT = 1'b1
) (
    input  logic                         i_clk,
    input  logic                         i_reset_n,
    input  logic                         i_enable,
    input  logic [1:0]                   i_mode,
    input  logic [CHANNELS-1:0]          i_ch_sel,
    input  logic [CHANNELS*WIDTH-1:0]    i_d,
    input  logic [CHANNELS-1:0]          i_serial_in,
    input  logic                         i_snap,
    input  logic                         i_snap_ack,
    output logic [CHANNELS*WIDTH-1:0]    o_q,
    output logic [CHANNELS-1:0]          o_serial_out,
    output logic [CHANNELS-1:0]          o_changed,
    output logic [CHANNELS*WIDTH-1:0]    o_q_snap,
    output logic                         o_snap_valid,
    output logic                         o_snap_ovf
);

    localparam logic [1:0] ModeHold  = 2'b00;
    localparam logic [1:0] ModeLoad  = 2'b01;
    localparam logic [1:0] ModeShift = 2'b10;
    localparam logic [1:0] ModeClear = 2'b11;

    logic [CHANNELS*WIDTH-1:0] r_q;
    logic [CHANNELS*WIDTH-1:0] r_q_snap;
    logic [CHANNELS-1:0]       r_changed;
    logic                      r_snap_valid;
    logic                      r_snap_ovf;

    logic [CHANNELS*WIDTH-1:0] w_q_next;
    logic [CHANNELS-1:0]       w_changed;

    // Next value of every channel from enable, per-channel select and mode.
    always_comb begin
        w_q_next = r_q;
        for (int i = 0; i < CHANNELS; i++) begin
            if (i_enable && i_ch_sel[i]) begin
                unique case (i_mode)
                    ModeHold:  w_q_next[i*WIDTH +: WIDTH] = r_q[i*WIDTH +: WIDTH];
                    ModeLoad:  w_q_next[i*WIDTH +: WIDTH] = i_d[i*WIDTH +: WIDTH];
                    ModeShift: begin
                        if (SHIFT_LEFT) begin
                            w_q_next[i*WIDTH +: WIDTH] =
                                {r_q[i*WIDTH +: WIDTH-1], i_serial_in[i]};
                        end else begin
                            w_q_next[i*WIDTH +: WIDTH] =
                                {i_serial_in[i], r_q[i*WIDTH+1 +: WIDTH-1]};
                        end
                    end
                    ModeClear: w_q_next[i*WIDTH +: WIDTH] = RESET_VAL;
                endcase
            end
        end
    end

    // Change detect compares the value about to be written with the current one,
    // so reloading an identical value produces no pulse.
    always_comb begin
        w_changed = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            w_changed[i] = (w_q_next[i*WIDTH +: WIDTH] != r_q[i*WIDTH +: WIDTH]);
        end
    end

    // Bit that leaves each channel on the next shift.
    always_comb begin
        o_serial_out = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            o_serial_out[i] = SHIFT_LEFT ? r_q[i*WIDTH + WIDTH - 1] : r_q[i*WIDTH];
        end
    end

    // Live register contents and their change pulses.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_q       <= {CHANNELS{RESET_VAL}};
            r_changed <= '0;
        end else begin
            r_q       <= w_q_next;
            r_changed <= w_changed;
        end
    end

    // Snapshot captures pre-update q; a capture while unconsumed data is pending
    // (and not being acknowledged on the same edge) sets the sticky overflow.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_q_snap     <= '0;
            r_snap_valid <= 1'b0;
            r_snap_ovf   <= 1'b0;
        end else if (i_snap) begin
            r_q_snap     <= r_q;
            r_snap_valid <= 1'b1;
            if (r_snap_valid && !i_snap_ack) begin
                r_snap_ovf <= 1'b1;
            end
        end else if (i_snap_ack) begin
            r_snap_valid <= 1'b0;
        end
    end

    assign o_q          = r_q;
    assign o_changed    = r_changed;
    assign o_q_snap     = r_q_snap;
    assign o_snap_valid = r_snap_valid;
    assign o_snap_ovf   = r_snap_ovf;

endmodule

// File: tb/tb_d_reg_bank.sv
// Directed self-checking bench for d_reg_bank (8-bit x 4 channels, shift left).
module tb_d_reg_bank;

    localparam int unsigned WIDTH    = 8;
    localparam int unsigned CHANNELS = 4;

    localparam logic [1:0] ModeHold  = 2'b00;
    localparam logic [1:0] ModeLoad  = 2'b01;
    localparam logic [1:0] ModeShift = 2'b10;
    localparam logic [1:0] ModeClear = 2'b11;

    logic                      clk;
    logic                      reset_n;
    logic                      enable;
    logic [1:0]                mode;
    logic [CHANNELS-1:0]       ch_sel;
    logic [CHANNELS*WIDTH-1:0] d;
    logic [CHANNELS-1:0]       serial_in;
    logic                      snap;
    logic                      snap_ack;
    logic [CHANNELS*WIDTH-1:0] q;
    logic [CHANNELS-1:0]       serial_out;
    logic [CHANNELS-1:0]       changed;
    logic [CHANNELS*WIDTH-1:0] q_snap;
    logic                      snap_valid;
    logic                      snap_ovf;

    int checks;
    int failures;

    d_reg_bank #(
        .WIDTH      (WIDTH),
        .CHANNELS   (CHANNELS),
        .RESET_VAL  (8'h00),
        .SHIFT_LEFT (1'b1)
    ) u_dut (
        .i_clk        (clk),
        .i_reset_n    (reset_n),
        .i_enable     (enable),
        .i_mode       (mode),
        .i_ch_sel     (ch_sel),
        .i_d          (d),
        .i_serial_in  (serial_in),
        .i_snap       (snap),
        .i_snap_ack   (snap_ack),
        .o_q          (q),
        .o_serial_out (serial_out),
        .o_changed    (changed),
        .o_q_snap     (q_snap),
        .o_snap_valid (snap_valid),
        .o_snap_ovf   (snap_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and sample shortly after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        reset_n   = 1'b0;
        enable    = 1'b0;
        mode      = ModeHold;
        ch_sel    = '0;
        d         = '0;
        serial_in = '0;
        snap      = 1'b0;
        snap_ack  = 1'b0;
        tick();
        tick();
        check("rst_q", q, 32'h0);
        check("rst_changed", changed, 4'h0);
        check("rst_qsnap", q_snap, 32'h0);
        check("rst_valid", snap_valid, 1'b0);
        check("rst_ovf", snap_ovf, 1'b0);
        #2 reset_n = 1'b1;

        // 1: load A5 everywhere, capture a snapshot, then reset mid-cycle.
        enable = 1'b1;
        mode   = ModeLoad;
        ch_sel = 4'hF;
        d      = 32'hA5A5A5A5;
        tick();
        check("t1_load_q", q, 32'hA5A5A5A5);
        check("t1_load_changed", changed, 4'hF);
        snap = 1'b1;
        tick();
        check("t1_snap_valid", snap_valid, 1'b1);
        check("t1_changed_clr", changed, 4'h0);
        snap = 1'b0;
        mode = ModeHold;
        #2 reset_n = 1'b0;
        #1;
        check("t1_async_q", q, 32'h0);
        check("t1_async_valid", snap_valid, 1'b0);
        check("t1_async_ovf", snap_ovf, 1'b0);
        check("t1_async_qsnap", q_snap, 32'h0);
        #1 reset_n = 1'b1;

        // 2: masked load, then identical reload gives no pulse.
        mode   = ModeLoad;
        ch_sel = 4'b0101;
        d      = 32'h44332211;
        tick();
        check("t2_q", q, 32'h00330011);
        check("t2_changed", changed, 4'b0101);
        tick();
        check("t2_reload_q", q, 32'h00330011);
        check("t2_reload_changed", changed, 4'b0000);

        // 3: shift ch0 left, then disabled shift holds.
        ch_sel = 4'b0001;
        d      = 32'h00000081;
        tick();
        check("t3_load81", q, 32'h00330081);
        check("t3_sout_before", serial_out, 4'b0001);
        mode      = ModeShift;
        serial_in = 4'b0000;
        tick();
        check("t3_shift_q", q, 32'h00330002);
        check("t3_sout_after", serial_out, 4'b0000);
        check("t3_shift_changed", changed, 4'b0001);
        enable = 1'b0;
        tick();
        check("t3_dis_q", q, 32'h00330002);
        check("t3_dis_changed", changed, 4'b0000);

        // 4: snapshot coincident with a load captures the pre-edge value.
        enable = 1'b1;
        mode   = ModeLoad;
        d      = 32'h00000011;
        tick();
        check("t4_pre_q", q, 32'h00330011);
        d    = 32'h00000099;
        snap = 1'b1;
        tick();
        check("t4_qsnap", q_snap, 32'h00330011);
        check("t4_q", q, 32'h00330099);
        check("t4_valid", snap_valid, 1'b1);
        snap     = 1'b0;
        mode     = ModeHold;
        snap_ack = 1'b1;
        tick();
        check("t4_ack_valid", snap_valid, 1'b0);
        check("t4_ack_qsnap", q_snap, 32'h00330011);
        tick();
        check("t4_ack_idle_valid", snap_valid, 1'b0);
        check("t4_ack_idle_ovf", snap_ovf, 1'b0);

        // 5: second snapshot without ack overflows; snap+ack keeps valid.
        snap_ack = 1'b0;
        snap     = 1'b1;
        tick();
        check("t5_snap1_qsnap", q_snap, 32'h00330099);
        check("t5_snap1_ovf", snap_ovf, 1'b0);
        snap = 1'b0;
        mode = ModeLoad;
        d    = 32'h00000055;
        tick();
        check("t5_q55", q, 32'h00330055);
        check("t5_still_valid", snap_valid, 1'b1);
        mode = ModeHold;
        snap = 1'b1;
        tick();
        check("t5_snap2_qsnap", q_snap, 32'h00330055);
        check("t5_snap2_ovf", snap_ovf, 1'b1);
        mode     = ModeLoad;
        d        = 32'h00000066;
        snap_ack = 1'b1;
        tick();
        check("t5_both_qsnap", q_snap, 32'h00330055);
        check("t5_both_valid", snap_valid, 1'b1);
        check("t5_both_ovf", snap_ovf, 1'b1);
        snap     = 1'b0;
        snap_ack = 1'b0;

        // 6: clear all channels.
        mode   = ModeLoad;
        ch_sel = 4'hF;
        d      = 32'h44332211;
        tick();
        check("t6_pre_q", q, 32'h44332211);
        mode = ModeClear;
        tick();
        check("t6_clear_q", q, 32'h0);
        check("t6_clear_changed", changed, 4'hF);
        tick();
        check("t6_clear_again", changed, 4'h0);

        // snap+ack on a valid snapshot with no prior overflow must not overflow.
        mode    = ModeHold;
        reset_n = 1'b0;
        #2 reset_n = 1'b1;
        mode   = ModeLoad;
        d      = 32'h01020304;
        tick();
        snap = 1'b1;
        mode = ModeHold;
        tick();
        check("t7_valid", snap_valid, 1'b1);
        snap_ack = 1'b1;
        tick();
        check("t7_both_valid", snap_valid, 1'b1);
        check("t7_both_ovf", snap_ovf, 1'b0);
        check("t7_qsnap", q_snap, 32'h01020304);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
